// File: rtl/sig_util_pkg.sv
// Shared types and default widths for the pulse event counter slice.
//   state_t          : run-control FSM states
//   C_CNT_WIDTH_DEF  : default width of the target and count registers
//   C_MIN_GAP_DEF    : default number of low cycles needed before a rise is accepted
package sig_util_pkg;

    localparam int unsigned C_CNT_WIDTH_DEF = 16;
    localparam int unsigned C_MIN_GAP_DEF   = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/edge_det_bit.sv
// Rising-edge detector with a minimum-low-gap qualifier.
//   clk, rst  : clock, synchronous active-high reset
//   ce        : clock enable; all state holds when low
//   data_in   : event level
//   rise      : data_in high now and low on the previous enabled cycle
//   gap_ok    : at least C_MIN_GAP consecutive low cycles preceded this cycle
module edge_det_bit #(
    parameter int unsigned C_MIN_GAP = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  logic data_in,
    output logic rise,
    output logic gap_ok
);

    logic r_data_in_d;

    // Previous sample; resets high so a level already high out of reset is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_in_d <= 1'b1;
        end else if (ce) begin
            r_data_in_d <= data_in;
        end
    end

    assign rise = data_in & ~r_data_in_d;

    generate
        if (C_MIN_GAP == 0) begin : g_no_gap
            assign gap_ok = 1'b1;
        end else begin : g_gap
            localparam int unsigned GAP_W = $clog2(C_MIN_GAP + 1);

            logic [GAP_W-1:0] r_gap_cnt;

            // Low-cycle run length, saturating at C_MIN_GAP, cleared by any high sample.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_gap_cnt <= '0;
                end else if (ce) begin
                    if (data_in) begin
                        r_gap_cnt <= '0;
                    end else if (r_gap_cnt != GAP_W'(C_MIN_GAP)) begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end
            end

            // Counter saturates at the threshold, so equality is the >= test.
            assign gap_ok = (r_gap_cnt == GAP_W'(C_MIN_GAP));
        end
    endgenerate

endmodule

// File: rtl/pulse_event_counter.sv
// Counts qualified rising edges of a stretched event level up to a programmed
// target, then pulses done for one enabled cycle.
//   clk, rst    : clock, synchronous active-high reset
//   ce          : clock enable; all state and outputs hold when low
//   start       : latch cfg_target and begin a run (ignored while busy)
//   abort       : return to IDLE without done; count holds
//   cfg_target  : number of events to count, sampled with start
//   data_in     : event level from the pulse-extender stage
//   busy        : high in ARM, COUNT and DONE
//   count       : events accepted in the current or last run
//   done        : high for the single enabled cycle spent in DONE
import sig_util_pkg::*;

module pulse_event_counter #(
    parameter int unsigned C_CNT_WIDTH = C_CNT_WIDTH_DEF,
    parameter int unsigned C_MIN_GAP   = C_MIN_GAP_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic                   start,
    input  logic                   abort,
    input  logic [C_CNT_WIDTH-1:0] cfg_target,
    input  logic                   data_in,
    output logic                   busy,
    output logic [C_CNT_WIDTH-1:0] count,
    output logic                   done
);

    state_t                 r_state;
    logic [C_CNT_WIDTH-1:0] r_target;
    logic [C_CNT_WIDTH-1:0] r_count;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_rise;
    logic                   w_gap_ok;
    logic                   w_accept;
    logic [C_CNT_WIDTH-1:0] w_count_inc;

    edge_det_bit #(
        .C_MIN_GAP (C_MIN_GAP)
    ) u_edge_det (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .data_in (data_in),
        .rise    (w_rise),
        .gap_ok  (w_gap_ok)
    );

    assign w_accept    = w_rise & w_gap_ok;
    // No wrap: the run ends when the increment reaches the target.
    assign w_count_inc = r_count + C_CNT_WIDTH'(1);

    // Run-control FSM; busy/done are registered alongside every state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_target <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (ce) begin
            if (abort) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_target <= cfg_target;
                            r_count  <= '0;
                            r_busy   <= 1'b1;
                            if (cfg_target == '0) begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= ARM;
                            end
                        end
                    end
                    // Wait for a low sample so a level already high at start is not counted.
                    ARM: begin
                        if (!data_in) begin
                            r_state <= COUNT;
                        end
                    end
                    COUNT: begin
                        if (w_accept) begin
                            r_count <= w_count_inc;
                            if (w_count_inc == r_target) begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy  = r_busy;
    assign count = r_count;
    assign done  = r_done;

endmodule

// File: tb/tb_pulse_event_counter.sv
// Directed bench for pulse_event_counter: one instance with a 1-cycle gap
// rule and one with a 2-cycle gap rule sharing all inputs except start.
module tb_pulse_event_counter;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        start;
    logic        start2;
    logic        abort;
    logic [15:0] cfg_target;
    logic        data_in;

    logic        busy;
    logic [15:0] count;
    logic        done;
    logic        busy2;
    logic [15:0] count2;
    logic        done2;

    int checks;
    int errors;

    pulse_event_counter #(
        .C_CNT_WIDTH (16),
        .C_MIN_GAP   (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .start      (start),
        .abort      (abort),
        .cfg_target (cfg_target),
        .data_in    (data_in),
        .busy       (busy),
        .count      (count),
        .done       (done)
    );

    pulse_event_counter #(
        .C_CNT_WIDTH (16),
        .C_MIN_GAP   (2)
    ) dut_gap2 (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .start      (start2),
        .abort      (abort),
        .cfg_target (cfg_target),
        .data_in    (data_in),
        .busy       (busy2),
        .count      (count2),
        .done       (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ce = 1'b1; data_in = 1'b1;
        repeat (3) tick();
        checks++;
        if (count !== 16'd0 || done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL reset_outputs: count=%0d done=%b busy=%b required 0 0 0", count, done, busy);
            errors++;
        end
        checks++;
        if (count2 !== 16'd0 || done2 !== 1'b0 || busy2 !== 1'b0) begin
            $display("FAIL reset_outputs_gap2: count=%0d done=%b busy=%b required 0 0 0", count2, done2, busy2);
            errors++;
        end
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if (count !== 16'd0 || busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL reset_release: count=%0d busy=%b done=%b required 0 0 0", count, busy, done);
            errors++;
        end
    endtask

    task automatic test_basic();
        int done_seen;
        done_seen = 0;
        data_in = 1'b0;
        repeat (3) tick();
        cfg_target = 16'd3; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || count !== 16'd0) begin
            $display("FAIL basic_start: busy=%b count=%0d required 1 0", busy, count);
            errors++;
        end
        tick();
        for (int rep = 0; rep < 3; rep++) begin
            for (int h = 0; h < 4; h++) begin
                data_in = 1'b1;
                tick();
                if (done) done_seen++;
                if (h == 0) begin
                    checks++;
                    if (count !== 16'(rep + 1) || done !== (rep == 2)) begin
                        $display("FAIL basic_count_rep%0d: count=%0d done=%b required %0d %b",
                                 rep, count, done, rep + 1, (rep == 2));
                        errors++;
                    end
                end
                if (rep == 2 && h == 1) begin
                    checks++;
                    if (busy !== 1'b0 || done !== 1'b0) begin
                        $display("FAIL basic_busy_fall: busy=%b done=%b required 0 0", busy, done);
                        errors++;
                    end
                end
            end
            data_in = 1'b0;
            repeat (2) begin
                tick();
                if (done) done_seen++;
            end
        end
        checks++;
        if (done_seen != 1 || count !== 16'd3) begin
            $display("FAIL basic_done_once: done_cycles=%0d count=%0d required 1 3", done_seen, count);
            errors++;
        end
    endtask

    task automatic test_merge();
        data_in = 1'b0;
        repeat (3) tick();
        cfg_target = 16'd2; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        tick();
        data_in = 1'b1; tick();
        checks++;
        if (count2 !== 16'd1 || done2 !== 1'b0) begin
            $display("FAIL merge_first: count=%0d done=%b required 1 0", count2, done2);
            errors++;
        end
        data_in = 1'b0; tick();
        data_in = 1'b1; tick();
        checks++;
        if (count2 !== 16'd1 || done2 !== 1'b0 || busy2 !== 1'b1) begin
            $display("FAIL merge_dropped: count=%0d done=%b busy=%b required 1 0 1", count2, done2, busy2);
            errors++;
        end
        data_in = 1'b0; tick();
        tick();
        data_in = 1'b1; tick();
        checks++;
        if (count2 !== 16'd2 || done2 !== 1'b1) begin
            $display("FAIL merge_third: count=%0d done=%b required 2 1", count2, done2);
            errors++;
        end
        tick();
        checks++;
        if (done2 !== 1'b0 || busy2 !== 1'b0 || count2 !== 16'd2) begin
            $display("FAIL merge_end: done=%b busy=%b count=%0d required 0 0 2", done2, busy2, count2);
            errors++;
        end
        data_in = 1'b0;
        tick();
    endtask

    task automatic test_high_at_start();
        data_in = 1'b1; cfg_target = 16'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (count !== 16'd0 || done !== 1'b0 || busy !== 1'b1) begin
                $display("FAIL high_hold_%0d: count=%0d done=%b busy=%b required 0 0 1", i, count, done, busy);
                errors++;
            end
        end
        data_in = 1'b0; tick();
        data_in = 1'b1; tick();
        checks++;
        if (count !== 16'd1 || done !== 1'b1) begin
            $display("FAIL high_second_rise: count=%0d done=%b required 1 1", count, done);
            errors++;
        end
        tick();
        data_in = 1'b0;
        tick();
    endtask

    task automatic test_stall_abort();
        cfg_target = 16'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        data_in = 1'b1; tick();
        checks++;
        if (done !== 1'b1) begin
            $display("FAIL stall_pre_done: done=%b required 1", done);
            errors++;
        end
        ce = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (done !== 1'b1 || busy !== 1'b1 || count !== 16'd1) begin
                $display("FAIL stall_hold_%0d: done=%b busy=%b count=%0d required 1 1 1", i, done, busy, count);
                errors++;
            end
        end
        ce = 1'b1;
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL stall_release: done=%b busy=%b required 0 0", done, busy);
            errors++;
        end
        data_in = 1'b0; cfg_target = 16'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        data_in = 1'b1; tick();
        data_in = 1'b0; tick();
        checks++;
        if (count !== 16'd1 || busy !== 1'b1) begin
            $display("FAIL abort_pre: count=%0d busy=%b required 1 1", count, busy);
            errors++;
        end
        abort = 1'b1; tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || count !== 16'd1) begin
            $display("FAIL abort_idle: busy=%b done=%b count=%0d required 0 0 1", busy, done, count);
            errors++;
        end
        data_in = 1'b1; tick();
        data_in = 1'b0; tick();
        data_in = 1'b1; tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || count !== 16'd1) begin
            $display("FAIL abort_after: busy=%b done=%b count=%0d required 0 0 1", busy, done, count);
            errors++;
        end
        data_in = 1'b0; tick();
    endtask

    task automatic test_edge_cases();
        cfg_target = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || count !== 16'd0 || busy !== 1'b1) begin
            $display("FAIL target0_done: done=%b count=%0d busy=%b required 1 0 1", done, count, busy);
            errors++;
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL target0_end: done=%b busy=%b required 0 0", done, busy);
            errors++;
        end
        cfg_target = 16'd2; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL start_abort_same: busy=%b done=%b required 0 0", busy, done);
            errors++;
        end
        tick();
        checks++;
        if (busy !== 1'b0 || count !== 16'd0) begin
            $display("FAIL start_abort_after: busy=%b count=%0d required 0 0", busy, count);
            errors++;
        end
        cfg_target = 16'd2; start = 1'b1;
        tick();
        cfg_target = 16'd1;
        tick();
        start = 1'b0;
        data_in = 1'b1; tick();
        checks++;
        if (count !== 16'd1 || done !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL start_busy_ignored: count=%0d done=%b busy=%b required 1 0 1", count, done, busy);
            errors++;
        end
        data_in = 1'b0; tick();
        data_in = 1'b1; tick();
        checks++;
        if (count !== 16'd2 || done !== 1'b1) begin
            $display("FAIL start_busy_target2: count=%0d done=%b required 2 1", count, done);
            errors++;
        end
        data_in = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; ce = 1'b1; start = 1'b0; start2 = 1'b0; abort = 1'b0;
        cfg_target = 16'd0; data_in = 1'b1;
        test_reset();
        test_basic();
        test_merge();
        test_high_at_start();
        test_stall_abort();
        test_edge_cases();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
